// File: rtl/deinterleaver_if.sv
// Bit-stream side of the deinterleaver: serial hard bits in, deinterleaved
// bit pairs out towards the Viterbi decoder.
interface deinterleaver_if;
    logic       iEN;
    logic       iData;
    logic       iMode;
    logic [1:0] oData;
    logic       oValid;
    logic       oSymEnd;

    modport master (
        output iEN,
        output iData,
        output iMode,
        input  oData,
        input  oValid,
        input  oSymEnd
    );

    modport slave (
        input  iEN,
        input  iData,
        input  iMode,
        output oData,
        output oValid,
        output oSymEnd
    );
endinterface

// File: rtl/deinterleaver.sv
// Block deinterleaver for 48-bit (BPSK) / 96-bit (QPSK) symbols: ping-pong
// banks written in column/row order, read back sequentially as bit pairs.
module deinterleaver (
    input  logic           iClk,
    input  logic           iRst,
    deinterleaver_if.slave io
);
    logic [95:0] bank0_q;
    logic [95:0] bank1_q;

    logic [2:0]  wr_col_q, wr_col_d;
    logic [3:0]  wr_row_q, wr_row_d;
    logic        wr_bank_q, wr_bank_d;
    logic        wr_qpsk_q, wr_qpsk_d;
    logic [1:0]  full_q, full_d;
    logic [1:0]  bank_qpsk_q, bank_qpsk_d;

    logic        rd_active_q, rd_active_d;
    logic        rd_bank_q, rd_bank_d;
    logic        rd_qpsk_q, rd_qpsk_d;
    logic [5:0]  rd_cnt_q, rd_cnt_d;

    logic [1:0]  odata_q, odata_d;
    logic        ovalid_q, ovalid_d;
    logic        osymend_q, osymend_d;

    logic        wr_first_s;
    logic        wr_qpsk_s;
    logic        wr_last_s;
    logic [2:0]  wr_last_col_s;
    logic [6:0]  wr_addr_s;
    logic        rd_last_s;
    logic [95:0] rd_bank_s;

    // The block size is taken from iMode only on bit 0; afterwards the latch rules.
    assign wr_first_s    = (wr_col_q == 3'd0) && (wr_row_q == 4'd0);
    assign wr_qpsk_s     = wr_first_s ? io.iMode : wr_qpsk_q;
    assign wr_last_col_s = wr_qpsk_s ? 3'd5 : 3'd2;
    assign wr_last_s     = (wr_col_q == wr_last_col_s) && (wr_row_q == 4'd15);
    assign wr_addr_s     = {wr_col_q, wr_row_q};
    assign rd_last_s     = (rd_cnt_q == (rd_qpsk_q ? 6'd47 : 6'd23));
    assign rd_bank_s     = rd_bank_q ? bank1_q : bank0_q;

    // Next-state logic for write counters, bank flags, read sequencer and outputs.
    always_comb begin
        wr_col_d    = wr_col_q;
        wr_row_d    = wr_row_q;
        wr_bank_d   = wr_bank_q;
        wr_qpsk_d   = wr_qpsk_q;
        full_d      = full_q;
        bank_qpsk_d = bank_qpsk_q;
        rd_active_d = rd_active_q;
        rd_bank_d   = rd_bank_q;
        rd_qpsk_d   = rd_qpsk_q;
        rd_cnt_d    = rd_cnt_q;
        odata_d     = 2'b00;
        ovalid_d    = 1'b0;
        osymend_d   = 1'b0;

        if (io.iEN) begin
            wr_qpsk_d = wr_qpsk_s;
            if (wr_last_s) begin
                wr_col_d  = 3'd0;
                wr_row_d  = 4'd0;
                wr_bank_d = ~wr_bank_q;
            end else if (wr_col_q == wr_last_col_s) begin
                wr_col_d = 3'd0;
                wr_row_d = wr_row_q + 4'd1;
            end else begin
                wr_col_d = wr_col_q + 3'd1;
            end
        end else begin
            wr_qpsk_d = wr_qpsk_q;
        end

        if (rd_active_q) begin
            ovalid_d  = 1'b1;
            odata_d   = {rd_bank_s[{rd_cnt_q, 1'b0}], rd_bank_s[{rd_cnt_q, 1'b1}]};
            osymend_d = rd_last_s;
            if (rd_last_s) begin
                rd_active_d       = 1'b0;
                rd_cnt_d          = 6'd0;
                rd_bank_d         = ~rd_bank_q;
                full_d[rd_bank_q] = 1'b0;
            end else begin
                rd_cnt_d = rd_cnt_q + 6'd1;
            end
        end else if (full_q[rd_bank_q]) begin
            rd_active_d = 1'b1;
            rd_cnt_d    = 6'd0;
            rd_qpsk_d   = bank_qpsk_q[rd_bank_q];
        end else begin
            rd_active_d = 1'b0;
        end

        // Applied after the read-side clear so a completing block always wins its flag.
        if (io.iEN && wr_last_s) begin
            full_d[wr_bank_q]      = 1'b1;
            bank_qpsk_d[wr_bank_q] = wr_qpsk_s;
        end else begin
            bank_qpsk_d = bank_qpsk_d;
        end
    end

    // State and output registers.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            wr_col_q    <= 3'd0;
            wr_row_q    <= 4'd0;
            wr_bank_q   <= 1'b0;
            wr_qpsk_q   <= 1'b0;
            full_q      <= 2'b00;
            bank_qpsk_q <= 2'b00;
            rd_active_q <= 1'b0;
            rd_bank_q   <= 1'b0;
            rd_qpsk_q   <= 1'b0;
            rd_cnt_q    <= 6'd0;
            odata_q     <= 2'b00;
            ovalid_q    <= 1'b0;
            osymend_q   <= 1'b0;
        end else begin
            wr_col_q    <= wr_col_d;
            wr_row_q    <= wr_row_d;
            wr_bank_q   <= wr_bank_d;
            wr_qpsk_q   <= wr_qpsk_d;
            full_q      <= full_d;
            bank_qpsk_q <= bank_qpsk_d;
            rd_active_q <= rd_active_d;
            rd_bank_q   <= rd_bank_d;
            rd_qpsk_q   <= rd_qpsk_d;
            rd_cnt_q    <= rd_cnt_d;
            odata_q     <= odata_d;
            ovalid_q    <= ovalid_d;
            osymend_q   <= osymend_d;
        end
    end

    // Each accepted bit lands directly at its deinterleaved address.
    always_ff @(posedge iClk) begin
        if (io.iEN) begin
            if (wr_bank_q) begin
                bank1_q[wr_addr_s] <= io.iData;
            end else begin
                bank0_q[wr_addr_s] <= io.iData;
            end
        end
    end

    assign io.oData   = odata_q;
    assign io.oValid  = ovalid_q;
    assign io.oSymEnd = osymend_q;
endmodule

// File: tb/tb_deinterleaver.sv
// Self-checking bench for deinterleaver: a per-cycle model of expected output
// pairs built from the inverse permutation, plus hand-computed pair values.
module tb_deinterleaver;
    logic iClk = 1'b0;
    logic iRst = 1'b0;

    deinterleaver_if dif ();

    deinterleaver dut (
        .iClk (iClk),
        .iRst (iRst),
        .io   (dif)
    );

    always #5 iClk = ~iClk;

    int cyc = 0;
    always @(posedge iClk) cyc <= cyc + 1;

    typedef struct packed {
        logic [31:0] cyc;
        logic [1:0]  d;
        logic        last;
    } exp_t;

    exp_t       exp_q[$];
    logic [1:0] dut_q[$];
    int         checks = 0;
    int         errors = 0;
    int         n_pairs = 0;
    int         n_symend = 0;
    int         first_valid = -1;
    int         mj = 0;
    logic       mqpsk = 1'b0;
    logic       blk[96];
    int         last_sched = -100;
    int         t_end = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: collect a block in arrival order; output position k takes input j = C*(k%16) + k/16.
    task automatic model_accept(input logic b, input logic m);
        int   n;
        int   c;
        int   start;
        int   k0;
        int   k1;
        exp_t e;
        if (mj == 0) mqpsk = m;
        n = mqpsk ? 96 : 48;
        c = n / 16;
        blk[mj] = b;
        if (mj == n - 1) begin
            start = (cyc + 2 > last_sched + 2) ? cyc + 2 : last_sched + 2;
            for (int p = 0; p < n / 2; p++) begin
                k0 = 2 * p;
                k1 = 2 * p + 1;
                e.cyc  = 32'(start + p);
                e.d    = {blk[c * (k0 % 16) + k0 / 16], blk[c * (k1 % 16) + k1 / 16]};
                e.last = (p == n / 2 - 1);
                exp_q.push_back(e);
            end
            last_sched = start + n / 2 - 1;
            t_end = cyc;
            mj = 0;
        end else begin
            mj++;
        end
    endtask

    task automatic send_bit(input logic b, input logic m, input int gap);
        repeat (gap) begin
            dif.iEN = 1'b0;
            @(posedge iClk);
            #1;
        end
        dif.iEN   = 1'b1;
        dif.iData = b;
        dif.iMode = m;
        @(posedge iClk);
        #1;
        model_accept(b, m);
        dif.iEN   = 1'b0;
        dif.iData = 1'b0;
    endtask

    task automatic do_reset();
        iRst = 1'b1;
        exp_q.delete();
        mj = 0;
        last_sched = -100;
        #1;
        check("rst_async", 32'({dif.oValid, dif.oSymEnd, dif.oData}), 32'd0);
        repeat (2) @(posedge iClk);
        #1;
        iRst = 1'b0;
    endtask

    task automatic new_test();
        n_pairs = 0;
        n_symend = 0;
        first_valid = -1;
        dut_q.delete();
    endtask

    task automatic wait_drain();
        int i = 0;
        while (exp_q.size() > 0 && i < 400) begin
            @(negedge iClk);
            #1;
            i++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
        repeat (4) @(negedge iClk);
        #1;
    endtask

    // Compare every cycle: either the scheduled pair or an all-zero idle output.
    always @(negedge iClk) begin
        exp_t       e;
        logic [3:0] want;
        if (iRst) begin
            check("rst_out", 32'({dif.oValid, dif.oSymEnd, dif.oData}), 32'd0);
        end else begin
            want = 4'b0000;
            if (exp_q.size() > 0 && exp_q[0].cyc == 32'(cyc)) begin
                e = exp_q.pop_front();
                want = {1'b1, e.last, e.d};
            end
            check("cyc_out", 32'({dif.oValid, dif.oSymEnd, dif.oData}), 32'(want));
            if (dif.oValid) begin
                dut_q.push_back(dif.oData);
                n_pairs++;
                if (first_valid < 0) first_valid = cyc;
            end
            if (dif.oSymEnd) n_symend++;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int i;
        dif.iEN   = 1'b0;
        dif.iData = 1'b0;
        dif.iMode = 1'b0;
        #2;
        do_reset();
        @(negedge iClk);
        #1;
        check("reset_state", 32'({dif.oValid, dif.oSymEnd, dif.oData}), 32'd0);

        // BPSK single one at j=1 -> k=16 -> pair 8 = 2'b10
        new_test();
        for (int j = 0; j < 48; j++) send_bit(j == 1, 1'b0, 0);
        wait_drain();
        check("bpsk1_pairs", 32'(n_pairs), 32'd24);
        check("bpsk1_symend", 32'(n_symend), 32'd1);
        check("bpsk1_p8", 32'(dut_q[8]), 32'd2);
        check("bpsk1_p7", 32'(dut_q[7]), 32'd0);
        check("bpsk1_latency", 32'(first_valid), 32'(t_end + 2));

        // QPSK single one at j=7 -> k=17 -> pair 8 = 2'b01
        new_test();
        for (int j = 0; j < 96; j++) send_bit(j == 7, 1'b1, 0);
        wait_drain();
        check("qpsk1_pairs", 32'(n_pairs), 32'd48);
        check("qpsk1_symend", 32'(n_symend), 32'd1);
        check("qpsk1_p8", 32'(dut_q[8]), 32'd1);
        check("qpsk1_p9", 32'(dut_q[9]), 32'd0);

        // BPSK alternating bits with random iEN gaps: pair0 = 01, pair8 = 10
        new_test();
        for (int j = 0; j < 48; j++) send_bit(1'(j % 2), 1'b0, int'($urandom_range(0, 3)));
        wait_drain();
        check("gap_pairs", 32'(n_pairs), 32'd24);
        check("gap_latency", 32'(first_valid), 32'(t_end + 2));
        check("gap_p0", 32'(dut_q[0]), 32'd1);
        check("gap_p8", 32'(dut_q[8]), 32'd2);

        // Back-to-back BPSK then QPSK, continuous stream
        new_test();
        for (int j = 0; j < 48; j++) send_bit(((j * 5) % 7) < 3, 1'b0, 0);
        for (int j = 0; j < 96; j++) send_bit(((j * 3) % 11) < 5, 1'b1, 0);
        wait_drain();
        check("mix_pairs", 32'(n_pairs), 32'd72);
        check("mix_symend", 32'(n_symend), 32'd2);

        // iMode toggled at j=20 of a BPSK block: ones at column 0 -> pairs 0..7 = 11
        new_test();
        for (int j = 0; j < 48; j++) send_bit((j % 3) == 0, j >= 20, 0);
        wait_drain();
        check("tog_pairs", 32'(n_pairs), 32'd24);
        check("tog_symend", 32'(n_symend), 32'd1);
        check("tog_p3", 32'(dut_q[3]), 32'd3);
        check("tog_p10", 32'(dut_q[10]), 32'd0);

        // Reset while pair 10 is on the outputs
        new_test();
        for (int j = 0; j < 48; j++) send_bit(1'b1, 1'b0, 0);
        i = 0;
        while (n_pairs < 11 && i < 100) begin
            @(negedge iClk);
            #1;
            i++;
        end
        check("rst_reach", 32'(n_pairs), 32'd11);
        do_reset();
        new_test();
        repeat (40) @(negedge iClk);
        #1;
        check("no_resume", 32'(n_pairs), 32'd0);

        // Partial QPSK block discarded by reset, then a clean BPSK block
        for (int j = 0; j < 10; j++) send_bit(1'b1, 1'b1, 0);
        do_reset();
        new_test();
        for (int j = 0; j < 48; j++) send_bit(1'(j % 2), 1'b0, 0);
        wait_drain();
        check("post_pairs", 32'(n_pairs), 32'd24);
        check("post_p0", 32'(dut_q[0]), 32'd1);
        check("post_p8", 32'(dut_q[8]), 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/deinterleaver.md
DEINTERLEAVER -- requirements
Module: deinterleaver

Interface
REQ-001 SHALL have parameter: none; block sizes are fixed at NCBPS=48 (BPSK) and NCBPS=96 (QPSK).
REQ-002 SHALL have port iClk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port iRst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port iEN  input  1  input bit qualifier; iData accepted on rising edge when high.
REQ-005 SHALL have port iData  input  1  serial demapped hard bit, interleaved order.
REQ-006 SHALL have port iMode  input  1  0 = BPSK (N=48), 1 = QPSK (N=96).
REQ-007 SHALL have port oData  output  2  deinterleaved bit pair for vitDecoder iData; oData[1] = even-index bit 2n, oData[0] = bit 2n+1.
REQ-008 SHALL have port oValid  output  1  oData qualifier; drives vitDecoder iEN.
REQ-009 SHALL have port oSymEnd  output  1  high with the last pair (n = N/2-1) of each block.

Function
REQ-010 SHALL store bits in two banks (ping-pong) of 96 bits each; one bank written while the other is read.
REQ-011 SHALL latch iMode into the write-side block size when the first bit (j=0) of a block is accepted; iMode changes at other times SHALL be ignored for that block.
REQ-012 SHALL write accepted bit j of a block to address k = 16*(j mod C) + floor(j/C), C = N/16 (C=3 BPSK, C=6 QPSK), using column/row counters (no multiplier/divider).
REQ-013 SHALL hold write counters while iEN is low; gaps of any length within a block are permitted.
REQ-014 SHALL, on acceptance of bit j=N-1, mark the bank full, swap write bank, reset write counters, and hand the block size to the read side.
REQ-015 SHALL read the full bank sequentially, one pair per cycle, n = 0..N/2-1, without gaps, independent of iEN.
REQ-016 SHALL register outputs: first pair of a block appears on the second rising edge after the edge accepting bit N-1 (latency 2 cycles).
REQ-017 SHALL hold oValid high for exactly N/2 consecutive cycles per block (24 BPSK, 48 QPSK).
REQ-018 SHALL drive oData = 2'b00 and oSymEnd = 0 whenever oValid is low.
REQ-019 SHALL use the read-side latched size, not current iMode, for read length; consecutive blocks of different modes SHALL each read correctly.
REQ-020 SHALL, for back-to-back blocks, start the next block's read the cycle after the previous oSymEnd at the earliest; no bubble beyond that; overflow is impossible since N/2 < N.
REQ-021 SHALL permit simultaneous write of bit 0 of block m+1 and read of block m in the same cycle without interference.

Reset
REQ-022 SHALL, on iRst high, immediately (asynchronously) force oValid=0, oData=2'b00, oSymEnd=0.
REQ-023 SHALL reset write/read counters to 0, write bank to 0, both banks empty, latched sizes to 48; bank contents are don't-care.
REQ-024 SHALL discard any partially written or partially read block on reset; first block after reset release starts at j=0.

Verification
REQ-025 SHALL verify BPSK single-one: iMode=0, 48 bits all 0 except j=1 -> k=16, 24 valid pairs, pair n=8 = 2'b10, all others 2'b00, oSymEnd on pair 23.
REQ-026 SHALL verify QPSK single-one: iMode=1, 96 bits all 0 except j=7 -> k=17, 48 valid pairs, pair n=8 = 2'b01, others 2'b00.
REQ-027 SHALL verify latency: BPSK block ending on edge t -> oValid rises after edge t+2, stays high 24 cycles; random iEN gaps within block do not change pair contents.
REQ-028 SHALL verify back-to-back mixed modes: BPSK block then QPSK block streamed continuously -> 24 then 48 valid pairs, each matching a MATLAB reference (deintrlv of encoded vector), oSymEnd twice.
REQ-029 SHALL verify iMode toggled at j=20 of a BPSK block -> block still 48 bits / 24 pairs.
REQ-030 SHALL verify reset mid-read: iRst asserted at pair 10 -> oValid=0 same cycle, no remaining pairs emitted after release; next full block decodes correctly.
